// File: rtl/debouncer_multi.sv
// rtl/debouncer_multi.sv - multi-channel switch debouncer with rise/fall pulses
//
// Each channel has a 2-flop synchroniser and a stability counter. The
// debounced level follows the synchronised input only after the input has
// disagreed with it for STABLE_CYCLES consecutive clocks.
//
// Ports:
//   clk_i      system clock, rising edge
//   rst_i      asynchronous active-high reset
//   sw_i       raw asynchronous switch inputs, bit n = channel n
//   db_o       debounced level per channel
//   rise_o     one-clock pulse when db_o[n] goes 0->1
//   fall_o     one-clock pulse when db_o[n] goes 1->0
//   any_chg_o  OR of all rise/fall pulses, aligned with them

module debouncer_multi #(
    parameter int             CH            = 4,
    parameter int             STABLE_CYCLES = 16,
    parameter int             CNT_W         = $clog2(STABLE_CYCLES),
    parameter logic [CH-1:0]  RST_VAL       = {CH{1'b0}}
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [CH-1:0] sw_i,
    output logic [CH-1:0] db_o,
    output logic [CH-1:0] rise_o,
    output logic [CH-1:0] fall_o,
    output logic          any_chg_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CH-1:0]            s1_q;
    logic [CH-1:0]            s2_q;
    logic [CH-1:0]            db_q,   db_d;
    logic [CH-1:0]            rise_q, rise_d;
    logic [CH-1:0]            fall_q, fall_d;
    logic                     any_q,  any_d;
    logic [CH-1:0][CNT_W-1:0] cnt_q,  cnt_d;

    // The counter encodes the per-channel state: zero while stable, counting
    // while the synchronised input disagrees with the debounced level.
    always_comb begin
        db_d   = db_q;
        cnt_d  = cnt_q;
        rise_d = '0;
        fall_d = '0;
        for (int n = 0; n < CH; n++) begin
            if (s2_q[n] == db_q[n]) begin
                // Any agreeing cycle (bounce back) restarts the count.
                cnt_d[n] = '0;
            end else if (cnt_q[n] == CNT_MAX) begin
                db_d[n]   = s2_q[n];
                cnt_d[n]  = '0;
                rise_d[n] = s2_q[n];
                fall_d[n] = ~s2_q[n];
            end else begin
                cnt_d[n] = cnt_q[n] + CNT_ONE;
            end
        end
        any_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q   <= RST_VAL;
            s2_q   <= RST_VAL;
            db_q   <= RST_VAL;
            cnt_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            any_q  <= 1'b0;
        end else begin
            s1_q   <= sw_i;
            s2_q   <= s1_q;
            db_q   <= db_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            any_q  <= any_d;
        end
    end

    assign db_o      = db_q;
    assign rise_o    = rise_q;
    assign fall_o    = fall_q;
    assign any_chg_o = any_q;

endmodule

// File: tb/tb_debouncer_multi.sv
// tb/tb_debouncer_multi.sv - scoreboard testbench for debouncer_multi

module tb_debouncer_multi;

    localparam int CH = 4;
    localparam int SC = 16;

    logic          clk_i;
    logic          rst_i;
    logic [CH-1:0] sw_i;
    logic [CH-1:0] db_o;
    logic [CH-1:0] rise_o;
    logic [CH-1:0] fall_o;
    logic          any_chg_o;

    debouncer_multi #(.CH(CH), .STABLE_CYCLES(SC), .RST_VAL(4'b0000)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .sw_i      (sw_i),
        .db_o      (db_o),
        .rise_o    (rise_o),
        .fall_o    (fall_o),
        .any_chg_o (any_chg_o)
    );

    typedef struct packed {
        logic [CH-1:0] db;
        logic [CH-1:0] rise;
        logic [CH-1:0] fall;
        logic          any;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Reference model: at edge t the debounce logic sees the sample taken two
    // edges earlier. The output follows once the last STABLE_CYCLES seen
    // samples all disagreed with it, i.e. STABLE_CYCLES edges have elapsed
    // since the last edge that agreed, flipped, or was in reset.
    initial begin : model
        int            edge_n;
        int            agree_at [CH];
        logic          smp1 [CH];
        logic          smp2 [CH];
        logic [CH-1:0] dbm;
        exp_t          e;
        logic          syn;
        edge_n = 0;
        dbm    = '0;
        for (int c = 0; c < CH; c++) begin
            agree_at[c] = 0;
            smp1[c]     = 1'b0;
            smp2[c]     = 1'b0;
        end
        forever begin
            @(posedge clk_i);
            edge_n++;
            e = '0;
            if (rst_i) begin
                dbm = '0;
                for (int c = 0; c < CH; c++) begin
                    smp1[c]     = 1'b0;
                    smp2[c]     = 1'b0;
                    agree_at[c] = edge_n;
                end
            end else begin
                for (int c = 0; c < CH; c++) begin
                    syn     = smp2[c];
                    smp2[c] = smp1[c];
                    smp1[c] = sw_i[c];
                    if (syn == dbm[c]) begin
                        agree_at[c] = edge_n;
                    end else if (edge_n - agree_at[c] == SC) begin
                        dbm[c]      = syn;
                        e.rise[c]   = syn;
                        e.fall[c]   = ~syn;
                        agree_at[c] = edge_n;
                    end
                end
                e.any = |(e.rise | e.fall);
            end
            e.db = dbm;
            exp_q.push_back(e);
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (db_o !== e.db || rise_o !== e.rise || fall_o !== e.fall || any_chg_o !== e.any) begin
                    bad++;
                    $display("FAIL scoreboard t=%0t: got db=%b rise=%b fall=%b any=%b, want db=%b rise=%b fall=%b any=%b",
                             $time, db_o, rise_o, fall_o, any_chg_o, e.db, e.rise, e.fall, e.any);
                end
            end
        end
    end

    // Waits up to 40 edges for the first rise (or fall) pulse and checks the
    // edge on which it appears, counted from the next rising edge.
    task automatic expect_pulse(input bit is_rise, input logic [CH-1:0] mask,
                                input int exp_edge, input string nm);
        int            k;
        logic [CH-1:0] p;
        bit            seen;
        seen = 1'b0;
        p    = '0;
        for (k = 1; k <= 40; k++) begin
            @(posedge clk_i);
            #1;
            p = is_rise ? rise_o : fall_o;
            if (p != '0) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen || k != exp_edge || p !== mask || any_chg_o !== 1'b1) begin
            bad++;
            $display("FAIL %s: edge=%0d pulses=%b any=%b, want edge=%0d pulses=%b any=1",
                     nm, k, p, any_chg_o, exp_edge, mask);
        end
    endtask

    initial begin : stim
        int   pulses;
        logic d1;
        rst_i = 1'b1;
        sw_i  = 4'hF;

        // Reset held with all switches pressed, then debounced afresh.
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        expect_pulse(1'b1, 4'hF, 18, "t1_rise_all");
        @(negedge clk_i);
        sw_i = 4'h0;
        expect_pulse(1'b0, 4'hF, 18, "t1_fall_all");

        // Clean press and release on ch0.
        @(negedge clk_i);
        sw_i = 4'b0001;
        expect_pulse(1'b1, 4'b0001, 18, "t2_rise_ch0");
        repeat (12) @(negedge clk_i);
        sw_i = 4'b0000;
        expect_pulse(1'b0, 4'b0001, 18, "t2_fall_ch0");
        repeat (5) @(negedge clk_i);

        // Bounce on ch1: every level lasts at most STABLE_CYCLES-1 clocks.
        pulses = 0;
        for (int it = 0; it < 50; it++) begin
            sw_i[1] = 1'b1;
            repeat ($urandom_range(1, 15)) begin
                @(negedge clk_i);
                if (rise_o[1] | fall_o[1]) pulses++;
            end
            sw_i[1] = 1'b0;
            repeat ($urandom_range(1, 15)) begin
                @(negedge clk_i);
                if (rise_o[1] | fall_o[1]) pulses++;
            end
        end
        total++;
        if (pulses != 0 || db_o[1] !== 1'b0) begin
            bad++;
            $display("FAIL t3_bounce: pulses=%0d db1=%b, want pulses=0 db1=0", pulses, db_o[1]);
        end
        sw_i[1] = 1'b1;
        expect_pulse(1'b1, 4'b0010, 18, "t3_rise_ch1");
        @(negedge clk_i);
        sw_i[1] = 1'b0;
        expect_pulse(1'b0, 4'b0010, 18, "t3_fall_ch1");

        // Threshold boundary on ch2: 15 clocks rejected, 16 accepted.
        @(negedge clk_i);
        sw_i[2] = 1'b1;
        repeat (15) @(negedge clk_i);
        sw_i[2] = 1'b0;
        repeat (20) @(negedge clk_i);
        total++;
        if (db_o[2] !== 1'b0) begin
            bad++;
            $display("FAIL t4_glitch15: db2=%b, want 0", db_o[2]);
        end
        sw_i[2] = 1'b1;
        repeat (16) @(negedge clk_i);
        sw_i[2] = 1'b0;
        expect_pulse(1'b1, 4'b0100, 2, "t4_glitch16_rise");
        expect_pulse(1'b0, 4'b0100, 16, "t4_glitch16_fall");

        // Simultaneous rise on ch0 and ch3 while ch1 bounces.
        @(negedge clk_i);
        d1      = db_o[1];
        sw_i[0] = 1'b1;
        sw_i[3] = 1'b1;
        fork
            expect_pulse(1'b1, 4'b1001, 18, "t5_simul");
            begin
                repeat (6) begin
                    sw_i[1] = ~sw_i[1];
                    repeat ($urandom_range(1, 3)) @(negedge clk_i);
                end
            end
        join
        total++;
        if (db_o[1] !== d1) begin
            bad++;
            $display("FAIL t5_ch1_hold: db1=%b, want %b", db_o[1], d1);
        end
        @(negedge clk_i);
        sw_i[0] = 1'b0;
        repeat (22) @(negedge clk_i);

        // Asynchronous reset mid-count, with ch3 debounced high beforehand.
        sw_i[0] = 1'b1;
        repeat (10) @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        total++;
        if (db_o !== 4'b0000 || rise_o !== 4'b0000 || fall_o !== 4'b0000 || any_chg_o !== 1'b0) begin
            bad++;
            $display("FAIL t6_async_rst: db=%b rise=%b fall=%b any=%b, want all 0",
                     db_o, rise_o, fall_o, any_chg_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        expect_pulse(1'b1, 4'b1001, 18, "t6_after_rst");

        repeat (4) @(negedge clk_i);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        bad++;
        $display("FAIL watchdog: time=%0t, want completion before 200000", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
